spdif_tx_framer: RTL

Parametrised S/PDIF (IEC 60958) transmitter that succeeds the fixed 32-bit stereo transmitter. It accepts stereo PCM samples of configurable width over a valid/ready handshake and builds complete 192-frame blocks: B/M/W preambles, validity, user, channel-status and parity bits, all biphase-mark coded. It sits between the I2S receiver/sample FIFO and the optical/coax output pin, with a clock divider that decouples the system clock from the line cell rate.

---
 rtl/spdif_tx_framer_if.sv | 12 +
 rtl/spdif_tx_framer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spdif_tx_framer_if.sv
// Sample-pair handshake between the upstream FIFO and the S/PDIF framer.
interface spdif_tx_framer_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/spdif_tx_framer.sv
// IEC 60958 transmitter: one-deep sample holding register, 192-frame block
// sequencing, preamble/V/U/C/P insertion and biphase-mark line coding.
module spdif_tx_framer #(
  parameter int DATA_W   = 24,
  parameter int CELL_DIV = 1,
  parameter int CS_W     = 40
) (
  input  logic                clk,
  input  logic                rst,
  spdif_tx_framer_if.slave    s_if,
  input  logic [CS_W-1:0]     cs_bits,
  output logic                spdif_out,
  output logic                block_start,
  output logic                underrun
);

  localparam int DIV_W = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  // Samples are MSB-aligned into the 24 audio slots.
  function automatic logic [23:0] align(input logic [DATA_W-1:0] s);
    return 24'(s) << (24 - DATA_W);
  endfunction

  function automatic logic slot_bit(input logic [4:0] slot, input logic [23:0] word,
                                    input logic v, input logic c, input logic par);
    logic [23:0] sh;
    sh = word >> (slot - 5'd4);
    case (slot)
      5'd28:   return v;
      5'd29:   return 1'b0;
      5'd30:   return c;
      5'd31:   return par;
      default: return sh[0];
    endcase
  endfunction

  function automatic logic pre_level(input logic [7:0] pat, input logic [2:0] idx,
                                     input logic inv);
    return pat[3'd7 - idx] ^ inv;
  endfunction

  logic [DIV_W-1:0]  r_div;
  logic              r_cell;
  logic [4:0]        r_slot;
  logic              r_sub;
  logic [7:0]        r_frame;
  logic              r_full;
  logic              r_ready;
  logic              r_out;
  logic              r_inv;
  logic              r_par;
  logic              r_blk;
  logic              r_ur;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [23:0]       r_word_l_p0;
  logic [23:0]       r_word_r_p0;
  logic              r_v_p0;
  logic [191:0]      r_cs;

  logic              w_stb;
  logic              w_fstart;
  logic              w_blk;
  logic              w_xfer;
  logic              w_move;
  logic              w_full_nxt;
  logic [7:0]        w_pat;
  logic [23:0]       w_word;
  logic              w_inv;
  logic              w_bit;
  logic              w_level;

  assign w_stb      = (r_div == '0);
  assign w_fstart   = w_stb && !r_sub && (r_slot == 5'd0) && !r_cell;
  assign w_blk      = w_fstart && (r_frame == 8'd0);
  assign w_xfer     = s_if.in_valid && r_ready;
  assign w_move     = w_fstart && r_full;
  assign w_full_nxt = w_move ? 1'b0 : (w_xfer ? 1'b1 : r_full);

  // Level of the cell loaded on the next strobe.
  always_comb begin
    w_pat   = PRE_W;
    w_word  = r_sub ? r_word_r_p0 : r_word_l_p0;
    w_inv   = (r_slot == 5'd0 && !r_cell) ? r_out : r_inv;
    w_bit   = slot_bit(r_slot, w_word, r_v_p0, r_cs[r_frame], r_par);
    w_level = 1'b0;
    if (!r_sub) w_pat = (r_frame == 8'd0) ? PRE_B : PRE_M;
    if (r_slot < 5'd4) w_level = pre_level(w_pat, {r_slot[1:0], r_cell}, w_inv);
    else if (!r_cell)  w_level = ~r_out;
    else               w_level = r_out ^ w_bit;
  end

  // Control stage: cell timing, frame position, handshake and line register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_cell  <= 1'b0;
      r_slot  <= 5'd0;
      r_sub   <= 1'b0;
      r_frame <= 8'd0;
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_out   <= 1'b0;
      r_inv   <= 1'b0;
      r_par   <= 1'b0;
      r_blk   <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      r_div   <= (r_div == DIV_W'(CELL_DIV - 1)) ? '0 : r_div + DIV_W'(1);
      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt && !w_move;
      r_blk   <= w_blk;
      r_ur    <= w_fstart && !r_full;
      if (w_stb) begin
        r_out  <= w_level;
        r_cell <= ~r_cell;
        if (r_slot < 5'd4) begin
          r_inv <= w_inv;
          r_par <= 1'b0;
        end else if (r_cell && r_slot != 5'd31) begin
          r_par <= r_par ^ w_bit;
        end
        if (r_cell) begin
          if (r_slot == 5'd31) begin
            r_slot <= 5'd0;
            r_sub  <= ~r_sub;
            if (r_sub) r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
          end else begin
            r_slot <= r_slot + 5'd1;
          end
        end
      end
    end
  end

  // Data stage: holding register, frame words and block channel status.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_hold_l <= s_if.in_left;
      r_hold_r <= s_if.in_right;
    end
    if (w_fstart) begin
      if (r_full) begin
        r_word_l_p0 <= align(r_hold_l);
        r_word_r_p0 <= align(r_hold_r);
        r_v_p0      <= 1'b0;
      end else begin
        r_word_l_p0 <= 24'd0;
        r_word_r_p0 <= 24'd0;
        r_v_p0      <= 1'b1;
      end
    end
    if (w_blk) r_cs <= 192'(cs_bits);
  end

  assign s_if.in_ready = r_ready;
  assign spdif_out     = r_out;
  assign block_start   = r_blk;
  assign underrun      = r_ur;

endmodule
